dff_pipe_bank: RTL and testbench

//  Parametrised register bank: WIDTH-bit, DEPTH-stage delay line of D flip-flops

---
 rtl/dff_pipe_bank.sv | 73 +++++++
 tb/tb_dff_pipe_bank.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe_bank.sv
// dff_pipe_bank: WIDTH x DEPTH enabled delay line with per-stage valid.
// Define DFF_PIPE_EDGE_DETECT_EN to build rise/fall detection on q.
module dff_pipe_bank #(
  parameter int              WIDTH     = 1,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       d,
  input  logic                   in_valid,
  output logic [WIDTH-1:0]       q,
  output logic                   out_valid,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [WIDTH-1:0]       rise,
  output logic [WIDTH-1:0]       fall
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("dff_pipe_bank: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0][WIDTH-1:0] r_stage;
  logic [DEPTH-1:0]            r_valid;
  logic                        w_flush;

  assign w_flush = !reset || clear;

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_stage <= {DEPTH{RESET_VAL}};
      r_valid <= '0;
    end else if (en) begin
      r_stage[0] <= d;
      r_valid[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  assign q         = r_stage[DEPTH-1];
  assign out_valid = r_valid[DEPTH-1];
  assign taps      = r_stage;

`ifdef DFF_PIPE_EDGE_DETECT_EN
  logic [WIDTH-1:0] r_hist;
  logic             r_hv;
  logic [WIDTH-1:0] w_qual;

  // History samples the old q so a pulse spans exactly one enabled cycle.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_hist <= RESET_VAL;
      r_hv   <= 1'b0;
    end else if (en) begin
      r_hist <= q;
      r_hv   <= out_valid;
    end
  end

  assign w_qual = {WIDTH{out_valid & r_hv}};
  assign rise   = q & ~r_hist & w_qual;
  assign fall   = ~q & r_hist & w_qual;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_dff_pipe_bank.sv
// tb_dff_pipe_bank: vector table, corner sequences and random run
// against a queue-style reference model for three configurations.
module tb_dff_pipe_bank;

`ifdef DFF_PIPE_EDGE_DETECT_EN
  localparam logic EDGE = 1'b1;
`else
  localparam logic EDGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, en, clear, in_valid;
  logic [3:0]  d;
  logic [0:0]  d2;

  logic [3:0]  q0, q1, rise0, rise1, fall0, fall1;
  logic [11:0] taps0, taps1;
  logic        ov0, ov1, ov2;
  logic [0:0]  q2, taps2, rise2, fall2;

  always #5 clk = ~clk;

  dff_pipe_bank #(.WIDTH(4), .DEPTH(3), .RESET_VAL(4'h0)) u0 (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .d(d),
    .in_valid(in_valid), .q(q0), .out_valid(ov0), .taps(taps0),
    .rise(rise0), .fall(fall0));

  dff_pipe_bank #(.WIDTH(4), .DEPTH(3), .RESET_VAL(4'hA)) u1 (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .d(d),
    .in_valid(in_valid), .q(q1), .out_valid(ov1), .taps(taps1),
    .rise(rise1), .fall(fall1));

  dff_pipe_bank #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u2 (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .d(d2),
    .in_valid(in_valid), .q(q2), .out_valid(ov2), .taps(taps2),
    .rise(rise2), .fall(fall2));

  int checks = 0;
  int errors = 0;

  // Reference model: each instance is a fixed-length slot line that
  // drops its oldest entry when a new one is pushed.
  int         dep[3] = '{3, 3, 1};
  logic [3:0] rv[3]  = '{4'h0, 4'hA, 4'h0};
  logic [3:0] msk[3] = '{4'hF, 4'hF, 4'h1};
  logic [3:0] md[3][3];
  logic       mv[3][3];
  logic [3:0] prev_q[3];
  logic       prev_v[3];

  task automatic chk(input string nm, input logic [11:0] act,
                     input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_taps(int k);
    logic [11:0] t = '0;
    for (int i = 0; i < dep[k]; i++)
      t[i*4 +: 4] = md[k][i];
    return t;
  endfunction

  task automatic model(input logic r, c, e, input logic [3:0] dd,
                       input logic iv);
    for (int k = 0; k < 3; k++) begin
      if (!r || c) begin
        for (int i = 0; i < 3; i++) begin
          md[k][i] = rv[k];
          mv[k][i] = 1'b0;
        end
        prev_q[k] = rv[k];
        prev_v[k] = 1'b0;
      end else if (e) begin
        prev_q[k] = md[k][dep[k]-1];
        prev_v[k] = mv[k][dep[k]-1];
        for (int i = 2; i > 0; i--) begin
          md[k][i] = md[k][i-1];
          mv[k][i] = mv[k][i-1];
        end
        md[k][0] = dd & msk[k];
        mv[k][0] = iv;
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] eq, er, ef;
    logic       ev;
    for (int k = 0; k < 3; k++) begin
      eq = md[k][dep[k]-1];
      ev = mv[k][dep[k]-1];
      er = (EDGE && ev && prev_v[k]) ? (eq & ~prev_q[k]) : 4'h0;
      ef = (EDGE && ev && prev_v[k]) ? (~eq & prev_q[k] & msk[k]) : 4'h0;
      case (k)
        0: begin
          chk("u0.q", {8'h0, q0}, {8'h0, eq});
          chk("u0.ov", {11'h0, ov0}, {11'h0, ev});
          chk("u0.taps", taps0, exp_taps(0));
          chk("u0.rise", {8'h0, rise0}, {8'h0, er});
          chk("u0.fall", {8'h0, fall0}, {8'h0, ef});
        end
        1: begin
          chk("u1.q", {8'h0, q1}, {8'h0, eq});
          chk("u1.ov", {11'h0, ov1}, {11'h0, ev});
          chk("u1.taps", taps1, exp_taps(1));
          chk("u1.rise", {8'h0, rise1}, {8'h0, er});
          chk("u1.fall", {8'h0, fall1}, {8'h0, ef});
        end
        default: begin
          chk("u2.q", {11'h0, q2}, {11'h0, eq[0]});
          chk("u2.ov", {11'h0, ov2}, {11'h0, ev});
          chk("u2.taps", {11'h0, taps2}, {11'h0, eq[0]});
          chk("u2.rise", {11'h0, rise2}, {11'h0, er[0]});
          chk("u2.fall", {11'h0, fall2}, {11'h0, ef[0]});
        end
      endcase
    end
  endtask

  task automatic step(input logic r, c, e, input logic [3:0] dd,
                      input logic iv);
    reset    = r;
    clear    = c;
    en       = e;
    d        = dd;
    d2       = dd[0];
    in_valid = iv;
    @(posedge clk);
    model(r, c, e, dd, iv);
    #1;
    compare_all();
  endtask

  typedef struct {
    logic        r, c, e;
    logic [3:0]  d;
    logic        iv;
    logic [3:0]  q;
    logic        ov;
    logic [11:0] taps;
  } vec_t;

  vec_t tbl[16];

  initial begin
    reset = 1'b0; clear = 1'b0; en = 1'b0;
    d = '0; d2 = '0; in_valid = 1'b0;

    tbl[0]  = '{1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 12'h000};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 12'h000};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 12'h00F};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 12'h0FF};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 4'hF, 1'b1, 12'hFFF};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 4'h1, 1'b1, 4'hF, 1'b1, 12'hFF1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 4'h2, 1'b1, 4'hF, 1'b1, 12'hF12};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 4'h3, 1'b1, 4'h1, 1'b1, 12'h123};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 4'h4, 1'b1, 4'h2, 1'b1, 12'h234};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 4'h9, 1'b1, 4'h0, 1'b0, 12'h000};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 4'h9, 1'b1, 4'h0, 1'b0, 12'h000};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 4'h0, 1'b0, 12'h005};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 4'h7, 1'b1, 4'h0, 1'b0, 12'h005};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 4'h6, 1'b1, 4'h0, 1'b0, 12'h056};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 4'h7, 1'b1, 4'h5, 1'b0, 12'h567};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 4'h8, 1'b1, 4'h6, 1'b1, 12'h678};

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].c, tbl[i].e, tbl[i].d, tbl[i].iv);
      chk($sformatf("vec%0d.q", i), {8'h0, q0}, {8'h0, tbl[i].q});
      chk($sformatf("vec%0d.ov", i), {11'h0, ov0}, {11'h0, tbl[i].ov});
      chk($sformatf("vec%0d.taps", i), taps0, tbl[i].taps);
    end

    // Flush on the non-zero reset value instance.
    step(1'b1, 1'b1, 1'b1, 4'h9, 1'b1);
    chk("rv_a_flush", taps1, 12'hAAA);
    chk("rv_a_q", {8'h0, q1}, 12'h00A);

    // Stall for two edges mid-stream, then resume.
    step(1'b1, 1'b0, 1'b1, 4'h1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 4'h2, 1'b1);
    step(1'b1, 1'b0, 1'b1, 4'h3, 1'b1);
    chk("pre_stall", taps0, 12'h123);
    step(1'b1, 1'b0, 1'b0, 4'h9, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'hE, 1'b1);
    chk("stall_taps", taps0, 12'h123);
    chk("stall_ov", {11'h0, ov0}, 12'h001);
    step(1'b1, 1'b0, 1'b1, 4'h4, 1'b1);
    chk("resume1", taps0, 12'h234);
    step(1'b1, 1'b0, 1'b1, 4'h5, 1'b1);
    chk("resume2", {8'h0, q0}, 12'h003);

    // Single-bit edge detect: d = 0,1,1,0.
    step(1'b0, 1'b0, 1'b1, 4'h0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 4'h0, 1'b1);
    chk("ed0.rise", {11'h0, rise2}, 12'h000);
    step(1'b1, 1'b0, 1'b1, 4'h1, 1'b1);
    chk("ed1.rise", {11'h0, rise2}, {11'h0, EDGE});
    step(1'b1, 1'b0, 1'b1, 4'h1, 1'b1);
    chk("ed2.rise", {11'h0, rise2}, 12'h000);
    step(1'b1, 1'b0, 1'b1, 4'h0, 1'b1);
    chk("ed3.fall", {11'h0, fall2}, {11'h0, EDGE});
    chk("ed3.rise", {11'h0, rise2}, 12'h000);

    // Reset with data in flight; flush must not pulse.
    step(1'b1, 1'b0, 1'b1, 4'h1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 4'h1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 4'hF, 1'b1);
    chk("mid_rst.ov0", {11'h0, ov0}, 12'h000);
    chk("mid_rst.taps", taps0, 12'h000);
    chk("mid_rst.fall", {11'h0, fall2}, 12'h000);
    step(1'b1, 1'b0, 1'b1, 4'h1, 1'b1);
    chk("first_valid.rise", {11'h0, rise2}, 12'h000);
    chk("first_valid.ov", {11'h0, ov2}, 12'h001);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) != 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 3) != 0),
           4'($urandom),
           1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
